bmp_binarize_reader: RTL and testbench

BMP_BINARIZE_READER -- requirements
Module: bmp_binarize_reader

---
 rtl/bmp_binarize_reader_pkg.sv | 46 ++++
 rtl/bmp_binarize_reader_gray_threshold.sv | 23 ++
 rtl/bmp_binarize_reader.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_bmp_binarize_reader.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmp_binarize_reader_pkg.sv
// Shared constants, types and helpers for the BMP binarizing reader.
// Holds the ROM geometry, BMP header field byte offsets, signature bytes,
// the supported pixel depth, the FSM state type and two small helpers.
package bmp_binarize_reader_pkg;

    // ROM geometry
    localparam int ADDR_WIDTH     = 16;
    localparam int BYTE_WIDTH     = 8;
    localparam int BMP_TOTAL_SIZE = 1024;

    // Byte offsets of the header fields we decode (all little-endian)
    localparam int HDR_SIG0_IDX   = 0;
    localparam int HDR_SIG1_IDX   = 1;
    localparam int HDR_OFFSET_IDX = 10;
    localparam int HDR_WIDTH_IDX  = 18;
    localparam int HDR_HEIGHT_IDX = 22;
    localparam int HDR_BPP_IDX    = 28;
    localparam int HDR_LAST_IDX   = 29;

    // "BM" signature and the only pixel depth we decode
    localparam logic [7:0]  BMP_SIG0   = 8'h42;
    localparam logic [7:0]  BMP_SIG1   = 8'h4D;
    localparam logic [15:0] BMP_BPP_24 = 16'd24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PIX,
        ST_EMIT,
        ST_DONE,
        ST_ERR
    } state_t;

    // Bytes of padding after each row so the next row starts 4-byte aligned
    function automatic logic [1:0] row_pad(input logic [15:0] width);
        logic [1:0] three_w;
        three_w = 2'(width[1:0] * 2'd3);
        return 2'd0 - three_w;
    endfunction

    // A read address is legal up to and including the image size
    function automatic logic addr_in_range(input logic [31:0] addr);
        return addr <= 32'(BMP_TOTAL_SIZE);
    endfunction

endpackage

// File: rtl/bmp_binarize_reader_gray_threshold.sv
// Combinational gray conversion and thresholding of one BGR pixel.
// gray = (B + 2*G + R) >> 2, summed in 10 bits so nothing overflows.
module bmp_gray_threshold
    import bmp_binarize_reader_pkg::*;
(
    input  logic [BYTE_WIDTH-1:0] blue,
    input  logic [BYTE_WIDTH-1:0] green,
    input  logic [BYTE_WIDTH-1:0] red,
    input  logic [7:0]            threshold,
    output logic [7:0]            pix_bin
);

    logic [9:0] gray_sum;
    logic [7:0] gray;

    // Weighted sum, divide by four, then compare against the threshold
    always_comb begin
        gray_sum = {2'b00, blue} + {1'b0, green, 1'b0} + {2'b00, red};
        gray     = gray_sum[9:2];
        pix_bin  = (gray >= threshold) ? 8'hFF : 8'h00;
    end

endmodule

// File: rtl/bmp_binarize_reader.sv
// BMP reader: parses a 24-bpp BMP header from a byte ROM, then walks the
// pixel array in file order, emitting one binarized byte per pixel over a
// valid/ready handshake. Each pixel costs three ROM reads (B, G, R) plus
// one capture cycle; no reads are issued while a pixel waits for the consumer.
module bmp_binarize_reader
    import bmp_binarize_reader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            threshold,
    output logic                  ROM_valid,
    output logic [ADDR_WIDTH-1:0] ROM_addr,
    input  logic [BYTE_WIDTH-1:0] ROM_out,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [7:0]            pix_data,
    output logic                  pix_eol,
    output logic                  pix_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    state_t                state_q, state_d;
    logic [7:0]            thr_q, thr_d;
    logic                  rom_valid_q, rom_valid_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;

    // Header capture: which header byte ROM_out carries this cycle
    logic                  cap_en_q, cap_en_d;
    logic [4:0]            cap_idx_q, cap_idx_d;

    logic [7:0]            sig0_q, sig0_d;
    logic [7:0]            sig1_q, sig1_d;
    logic [31:0]           offset_q, offset_d;
    logic [15:0]           width_q, width_d;
    logic [15:0]           height_q, height_d;
    logic [15:0]           bpp_q, bpp_d;

    // Pixel walk
    logic [31:0]           ptr_q, ptr_d;
    logic [1:0]            phase_q, phase_d;
    logic [15:0]           col_q, col_d;
    logic [15:0]           row_q, row_d;
    logic [7:0]            b_q, b_d;
    logic [7:0]            g_q, g_d;

    logic                  pix_valid_q, pix_valid_d;
    logic [7:0]            pix_data_q, pix_data_d;
    logic                  pix_eol_q, pix_eol_d;
    logic                  pix_last_q, pix_last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    // Combinational helpers
    logic                  req_en;
    logic [31:0]           req_addr;
    logic [31:0]           next_ptr;
    logic                  last_col;
    logic                  last_row;
    logic [15:0]           bpp_full;
    logic [7:0]            pix_bin;

    // Red is consumed straight from ROM_out in the capture cycle
    bmp_gray_threshold u_gray (
        .blue      (b_q),
        .green     (g_q),
        .red       (ROM_out),
        .threshold (thr_q),
        .pix_bin   (pix_bin)
    );

    // Next-state logic: header parse, pixel fetch, emit handshake and bounds guard
    always_comb begin
        state_d     = state_q;
        thr_d       = thr_q;
        rom_valid_d = 1'b0;
        rom_addr_d  = rom_addr_q;
        cap_en_d    = rom_valid_q && (state_q == ST_HDR);
        cap_idx_d   = rom_addr_q[4:0];
        sig0_d      = sig0_q;
        sig1_d      = sig1_q;
        offset_d    = offset_q;
        width_d     = width_q;
        height_d    = height_q;
        bpp_d       = bpp_q;
        ptr_d       = ptr_q;
        phase_d     = phase_q;
        col_d       = col_q;
        row_d       = row_q;
        b_d         = b_q;
        g_d         = g_q;
        pix_valid_d = pix_valid_q;
        pix_data_d  = pix_data_q;
        pix_eol_d   = pix_eol_q;
        pix_last_d  = pix_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        req_en      = 1'b0;
        req_addr    = '0;
        next_ptr    = '0;
        last_col    = (col_q == width_q - 16'd1);
        last_row    = (row_q == height_q - 16'd1);
        bpp_full    = {ROM_out, bpp_q[7:0]};

        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    state_d  = ST_HDR;
                    busy_d   = 1'b1;
                    err_d    = 1'b0;
                    thr_d    = threshold;
                    sig0_d   = '0;
                    sig1_d   = '0;
                    offset_d = '0;
                    width_d  = '0;
                    height_d = '0;
                    bpp_d    = '0;
                    ptr_d    = '0;
                    phase_d  = '0;
                    col_d    = '0;
                    row_d    = '0;
                    req_en   = 1'b1;
                    req_addr = '0;
                end
            end

            ST_HDR: begin
                if (rom_valid_q && (rom_addr_q < ADDR_WIDTH'(HDR_LAST_IDX))) begin
                    req_en   = 1'b1;
                    req_addr = 32'(rom_addr_q) + 32'd1;
                end
                if (cap_en_q) begin
                    case (cap_idx_q)
                        5'(HDR_SIG0_IDX):       sig0_d          = ROM_out;
                        5'(HDR_SIG1_IDX):       sig1_d          = ROM_out;
                        5'(HDR_OFFSET_IDX):     offset_d[7:0]   = ROM_out;
                        5'(HDR_OFFSET_IDX + 1): offset_d[15:8]  = ROM_out;
                        5'(HDR_OFFSET_IDX + 2): offset_d[23:16] = ROM_out;
                        5'(HDR_OFFSET_IDX + 3): offset_d[31:24] = ROM_out;
                        5'(HDR_WIDTH_IDX):      width_d[7:0]    = ROM_out;
                        5'(HDR_WIDTH_IDX + 1):  width_d[15:8]   = ROM_out;
                        5'(HDR_HEIGHT_IDX):     height_d[7:0]   = ROM_out;
                        5'(HDR_HEIGHT_IDX + 1): height_d[15:8]  = ROM_out;
                        5'(HDR_BPP_IDX):        bpp_d[7:0]      = ROM_out;
                        5'(HDR_BPP_IDX + 1):    bpp_d[15:8]     = ROM_out;
                        default: ;
                    endcase
                    // Last header byte is in hand: validate and pick the next phase
                    if (cap_idx_q == 5'(HDR_LAST_IDX)) begin
                        if ((sig0_q != BMP_SIG0) || (sig1_q != BMP_SIG1) ||
                            (bpp_full != BMP_BPP_24)) begin
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                            busy_d  = 1'b0;
                        end else if ((width_q == 16'd0) || (height_q == 16'd0)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d  = ST_PIX;
                            ptr_d    = offset_q;
                            phase_d  = 2'd0;
                            req_en   = 1'b1;
                            req_addr = offset_q;
                        end
                    end
                end
            end

            ST_PIX: begin
                case (phase_q)
                    2'd0: begin
                        phase_d  = 2'd1;
                        req_en   = 1'b1;
                        req_addr = ptr_q + 32'd1;
                    end
                    2'd1: begin
                        b_d      = ROM_out;
                        phase_d  = 2'd2;
                        req_en   = 1'b1;
                        req_addr = ptr_q + 32'd2;
                    end
                    2'd2: begin
                        g_d     = ROM_out;
                        phase_d = 2'd3;
                    end
                    default: begin
                        pix_data_d  = pix_bin;
                        pix_eol_d   = last_col;
                        pix_last_d  = last_col && last_row;
                        pix_valid_d = 1'b1;
                        phase_d     = 2'd0;
                        state_d     = ST_EMIT;
                    end
                endcase
            end

            ST_EMIT: begin
                if (pix_ready) begin
                    pix_valid_d = 1'b0;
                    pix_eol_d   = 1'b0;
                    pix_last_d  = 1'b0;
                    if (last_col && last_row) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        if (last_col) begin
                            col_d    = '0;
                            row_d    = row_q + 16'd1;
                            next_ptr = ptr_q + 32'd3 + 32'(row_pad(width_q));
                        end else begin
                            col_d    = col_q + 16'd1;
                            next_ptr = ptr_q + 32'd3;
                        end
                        ptr_d    = next_ptr;
                        phase_d  = 2'd0;
                        state_d  = ST_PIX;
                        req_en   = 1'b1;
                        req_addr = next_ptr;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: state_d = ST_IDLE;
        endcase

        // Every ROM request funnels through here so an out-of-range address
        // aborts the image instead of being issued
        if (req_en) begin
            if (addr_in_range(req_addr)) begin
                rom_valid_d = 1'b1;
                rom_addr_d  = req_addr[ADDR_WIDTH-1:0];
            end else begin
                state_d     = ST_ERR;
                err_d       = 1'b1;
                busy_d      = 1'b0;
                pix_valid_d = 1'b0;
                pix_eol_d   = 1'b0;
                pix_last_d  = 1'b0;
            end
        end
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            thr_q       <= '0;
            rom_valid_q <= 1'b0;
            rom_addr_q  <= '0;
            cap_en_q    <= 1'b0;
            cap_idx_q   <= '0;
            sig0_q      <= '0;
            sig1_q      <= '0;
            offset_q    <= '0;
            width_q     <= '0;
            height_q    <= '0;
            bpp_q       <= '0;
            ptr_q       <= '0;
            phase_q     <= '0;
            col_q       <= '0;
            row_q       <= '0;
            b_q         <= '0;
            g_q         <= '0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            pix_eol_q   <= 1'b0;
            pix_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            thr_q       <= thr_d;
            rom_valid_q <= rom_valid_d;
            rom_addr_q  <= rom_addr_d;
            cap_en_q    <= cap_en_d;
            cap_idx_q   <= cap_idx_d;
            sig0_q      <= sig0_d;
            sig1_q      <= sig1_d;
            offset_q    <= offset_d;
            width_q     <= width_d;
            height_q    <= height_d;
            bpp_q       <= bpp_d;
            ptr_q       <= ptr_d;
            phase_q     <= phase_d;
            col_q       <= col_d;
            row_q       <= row_d;
            b_q         <= b_d;
            g_q         <= g_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            pix_eol_q   <= pix_eol_d;
            pix_last_q  <= pix_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign ROM_valid = rom_valid_q;
    assign ROM_addr  = rom_addr_q;
    assign pix_valid = pix_valid_q;
    assign pix_data  = pix_data_q;
    assign pix_eol   = pix_eol_q;
    assign pix_last  = pix_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bmp_binarize_reader.sv
// Scoreboard bench for bmp_binarize_reader: builds BMP images in a model
// ROM, predicts the read addresses and binarized pixels, and compares them
// against the DUT as pixels are handshaken.
module tb_bmp_binarize_reader;
    import bmp_binarize_reader_pkg::*;

    localparam int ROM_DEPTH = BMP_TOTAL_SIZE + 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic [7:0]            threshold;
    logic                  ROM_valid;
    logic [ADDR_WIDTH-1:0] ROM_addr;
    logic [BYTE_WIDTH-1:0] ROM_out;
    logic                  pix_valid;
    logic                  pix_ready;
    logic [7:0]            pix_data;
    logic                  pix_eol;
    logic                  pix_last;
    logic                  busy;
    logic                  done;
    logic                  err;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] rom_mem [0:ROM_DEPTH-1];
    logic [9:0] exp_pix_q[$];
    int         exp_addr_q[$];
    int         act_addr_q[$];
    bit         exp_err;
    bit         exp_done;

    always #5 clk = ~clk;

    // Synchronous ROM: data appears the cycle after the request
    always_ff @(posedge clk) begin
        if (ROM_valid) ROM_out <= rom_mem[ROM_addr[10:0]];
    end

    bmp_binarize_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .threshold (threshold),
        .ROM_valid (ROM_valid),
        .ROM_addr  (ROM_addr),
        .ROM_out   (ROM_out),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .pix_eol   (pix_eol),
        .pix_last  (pix_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Fill the ROM with an image and push the expected reads and pixels
    task automatic build_image(input logic [7:0] sig1, input int offset, input int w,
                               input int h, input int bpp, input bit rnd,
                               input logic [7:0] cr, input logic [7:0] cg,
                               input logic [7:0] cb, input logic [7:0] thr);
        int pad, row_bytes, base, gray;
        bit stop;
        logic [7:0] pb, pg, pr, pd;
        exp_pix_q.delete();
        exp_addr_q.delete();
        for (int i = 0; i < ROM_DEPTH; i++) rom_mem[i] = 8'h00;
        rom_mem[0]  = 8'h42;
        rom_mem[1]  = sig1;
        rom_mem[10] = offset[7:0];
        rom_mem[11] = offset[15:8];
        rom_mem[12] = offset[23:16];
        rom_mem[13] = offset[31:24];
        rom_mem[18] = w[7:0];
        rom_mem[19] = w[15:8];
        rom_mem[22] = h[7:0];
        rom_mem[23] = h[15:8];
        rom_mem[28] = bpp[7:0];
        rom_mem[29] = bpp[15:8];
        for (int a = 0; a < 30; a++) exp_addr_q.push_back(a);
        exp_err  = 1'b0;
        exp_done = 1'b0;
        if (sig1 != 8'h4D || bpp != 24) begin
            exp_err = 1'b1;
        end else if (w == 0 || h == 0) begin
            exp_done = 1'b1;
        end else begin
            pad       = (4 - ((3 * w) % 4)) % 4;
            row_bytes = 3 * w + pad;
            stop      = 1'b0;
            for (int r = 0; r < h; r++) begin
                for (int c = 0; c < w; c++) begin
                    base = offset + r * row_bytes + c * 3;
                    for (int k = 0; k < 3; k++) begin
                        if (!stop) begin
                            if (base + k > BMP_TOTAL_SIZE) stop = 1'b1;
                            else exp_addr_q.push_back(base + k);
                        end
                    end
                    if (!stop) begin
                        pb = rnd ? 8'($urandom_range(0, 255)) : cb;
                        pg = rnd ? 8'($urandom_range(0, 255)) : cg;
                        pr = rnd ? 8'($urandom_range(0, 255)) : cr;
                        rom_mem[base]     = pb;
                        rom_mem[base + 1] = pg;
                        rom_mem[base + 2] = pr;
                        gray = (int'(pb) + 2 * int'(pg) + int'(pr)) / 4;
                        pd   = (gray >= int'(thr)) ? 8'hFF : 8'h00;
                        exp_pix_q.push_back({(c == w - 1), (c == w - 1 && r == h - 1), pd});
                    end
                end
            end
            exp_err  = stop;
            exp_done = !stop;
        end
    endtask

    // Start one image, act as consumer, score pixels as they are accepted
    task automatic run_image(input string name, input logic [7:0] thr, input int budget,
                             input int stall_idx, input int stall_len,
                             input int extra_start_at, input int abort_after);
        int n_pix, cyc, stall_cnt, bad_idx;
        bit saw_done, saw_err, aborted;
        logic [9:0] held, got, e;
        n_pix = 0; cyc = 0; stall_cnt = 0; held = '0;
        saw_done = 0; saw_err = 0; aborted = 0;
        act_addr_q.delete();
        @(negedge clk);
        threshold = thr;
        start     = 1'b1;
        while (1) begin
            @(negedge clk);
            start = (cyc == extra_start_at);
            cyc++;
            if (cyc == 1) begin
                n_checks++;
                if (busy !== 1'b1 || err !== 1'b0)
                    $display("FAIL %s start_state: busy=%b err=%b expected busy=1 err=0", name, busy, err);
                if (busy !== 1'b1 || err !== 1'b0) n_errors++;
            end
            if (ROM_valid) act_addr_q.push_back(int'(ROM_addr));
            if (err) begin saw_err = 1; break; end
            if (done) begin
                saw_done = 1;
                @(negedge clk);
                n_checks++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    n_errors++;
                    $display("FAIL %s done_pulse: done=%b busy=%b expected 0 0", name, done, busy);
                end
                break;
            end
            if (pix_valid) begin
                got = {pix_eol, pix_last, pix_data};
                if (n_pix == stall_idx && stall_cnt < stall_len) begin
                    n_checks++;
                    if (ROM_valid !== 1'b0 || (stall_cnt > 0 && got !== held)) begin
                        n_errors++;
                        $display("FAIL %s stall_hold: got %h rom_valid=%b expected %h rom_valid=0", name, got, ROM_valid, held);
                    end
                    if (stall_cnt == 0) held = got;
                    stall_cnt++;
                    pix_ready = 1'b0;
                end else begin
                    pix_ready = 1'b1;
                    n_checks++;
                    if (exp_pix_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL %s unexpected_pixel: got %h expected none", name, got);
                    end else begin
                        e = exp_pix_q.pop_front();
                        if (got !== e) begin
                            n_errors++;
                            $display("FAIL %s pixel%0d: got eol,last,data=%h expected %h", name, n_pix, got, e);
                        end
                    end
                    $display("%s pixel %0d data=%h eol=%b last=%b", name, n_pix, pix_data, pix_eol, pix_last);
                    n_pix++;
                    if (n_pix == abort_after) begin aborted = 1; break; end
                end
            end else begin
                pix_ready = 1'b0;
            end
            if (cyc >= budget) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s timeout: got no done/err within %0d cycles expected completion", name, budget);
                break;
            end
        end
        start = 1'b0;
        if (!aborted) begin
            pix_ready = 1'b0;
            n_checks++;
            if (exp_pix_q.size() != 0) begin
                n_errors++;
                $display("FAIL %s pix_count: got %0d pixels expected %0d more", name, n_pix, exp_pix_q.size());
            end
            n_checks++;
            if (saw_done !== exp_done || saw_err !== exp_err) begin
                n_errors++;
                $display("FAIL %s end_status: got done=%b err=%b expected done=%b err=%b", name, saw_done, saw_err, exp_done, exp_err);
            end
            bad_idx = -1;
            for (int i = 0; i < exp_addr_q.size(); i++)
                if (bad_idx < 0 && (i >= act_addr_q.size() || act_addr_q[i] != exp_addr_q[i])) bad_idx = i;
            if (bad_idx < 0 && act_addr_q.size() != exp_addr_q.size()) bad_idx = exp_addr_q.size();
            n_checks++;
            if (bad_idx >= 0) begin
                n_errors++;
                $display("FAIL %s addr_seq: got %0d reads, first diff at %0d, expected %0d reads", name, act_addr_q.size(), bad_idx, exp_addr_q.size());
            end
            $display("%s finished: pixels=%0d reads=%0d done=%b err=%b", name, n_pix, act_addr_q.size(), saw_done, saw_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; pix_ready = 1'b0; threshold = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ROM_valid, ROM_addr, pix_valid, pix_data, pix_eol, pix_last, busy, done, err} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got rv=%b addr=%h pv=%b data=%h busy=%b done=%b err=%b expected all 0",
                     ROM_valid, ROM_addr, pix_valid, pix_data, busy, done, err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || ROM_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle: got busy=%b rv=%b expected 0 0", busy, ROM_valid);
        end
        $display("reset checked");
    endtask

    task automatic test_basic_2x2();
        build_image(8'h4D, 54, 2, 2, 24, 1'b0, 8'd200, 8'd200, 8'd200, 8'd128);
        run_image("basic_2x2", 8'd128, 2000, -1, 0, -1, -1);
    endtask

    task automatic test_gray_boundary();
        build_image(8'h4D, 54, 1, 1, 24, 1'b0, 8'd0, 8'd255, 8'd0, 8'd128);
        run_image("gray_thr128", 8'd128, 2000, -1, 0, -1, -1);
        build_image(8'h4D, 54, 1, 1, 24, 1'b0, 8'd0, 8'd255, 8'd0, 8'd127);
        run_image("gray_thr127", 8'd127, 2000, -1, 0, -1, -1);
    endtask

    task automatic test_bad_signature();
        build_image(8'h00, 54, 2, 2, 24, 1'b0, 8'd200, 8'd200, 8'd200, 8'd128);
        run_image("bad_sig", 8'd128, 2000, -1, 0, -1, -1);
        repeat (4) @(negedge clk);
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0 || pix_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL bad_sig_hold: got err=%b busy=%b pv=%b expected 1 0 0", err, busy, pix_valid);
        end
        // Next start must clear err (checked at start) and run normally
        build_image(8'h4D, 54, 2, 1, 24, 1'b1, 8'd0, 8'd0, 8'd0, 8'd90);
        run_image("after_err", 8'd90, 2000, -1, 0, -1, -1);
    endtask

    task automatic test_stall();
        build_image(8'h4D, 60, 3, 2, 24, 1'b1, 8'd0, 8'd0, 8'd0, 8'd110);
        run_image("stall_3x2", 8'd110, 2000, 1, 5, -1, -1);
    endtask

    task automatic test_reset_mid();
        build_image(8'h4D, 54, 4, 4, 24, 1'b1, 8'd0, 8'd0, 8'd0, 8'd100);
        run_image("abort_4x4", 8'd100, 2000, -1, 0, -1, 3);
        @(posedge clk);
        pix_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ROM_valid, ROM_addr, pix_valid, pix_data, pix_eol, pix_last, busy, done, err} !== '0) begin
            n_errors++;
            $display("FAIL midreset_outputs: got rv=%b addr=%h pv=%b busy=%b expected all 0", ROM_valid, ROM_addr, pix_valid, busy);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ROM_valid !== 1'b0 || pix_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_quiet: got rv=%b pv=%b busy=%b expected 0 0 0", ROM_valid, pix_valid, busy);
        end
        build_image(8'h4D, 54, 4, 4, 24, 1'b1, 8'd0, 8'd0, 8'd0, 8'd100);
        run_image("full_4x4", 8'd100, 2000, -1, 0, -1, -1);
    endtask

    task automatic test_zero_width();
        build_image(8'h4D, 54, 0, 2, 24, 1'b0, 8'd0, 8'd0, 8'd0, 8'd128);
        run_image("zero_width", 8'd128, 2000, -1, 0, 8, -1);
    endtask

    task automatic test_bounds();
        build_image(8'h4D, 1020, 2, 1, 24, 1'b0, 8'd250, 8'd250, 8'd250, 8'd10);
        run_image("bounds", 8'd10, 2000, -1, 0, -1, -1);
    endtask

    task automatic test_back_to_back();
        build_image(8'h4D, 54, 2, 1, 24, 1'b1, 8'd0, 8'd0, 8'd0, 8'd50);
        run_image("b2b_a", 8'd50, 2000, -1, 0, -1, -1);
        build_image(8'h4D, 70, 1, 2, 24, 1'b1, 8'd0, 8'd0, 8'd0, 8'd200);
        run_image("b2b_b", 8'd200, 2000, -1, 0, -1, -1);
    endtask

    initial begin
        test_reset();
        test_basic_2x2();
        test_gray_boundary();
        test_bad_signature();
        test_stall();
        test_reset_mid();
        test_zero_width();
        test_bounds();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
